// File: rtl/rr_arb_n.sv
// rr_arb_n: N-requester round-robin arbiter with a registered one-hot grant.
// The owner keeps the grant until it drops its request. An optional
// MAX_HOLD limit ends a tenure after MAX_HOLD consecutive granted cycles.
// There is always one dead cycle between two tenures.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous, active-low reset
//   request[N]   - request level per requester (bit i = requester i)
//   grant[N]     - registered one-hot grant, or all zero
//   grant_id     - index of the current/last owner (valid when grant_valid)
//   grant_valid  - registered, high while any grant bit is set
//   hold_expired - registered one-cycle pulse when MAX_HOLD cuts a tenure
module rr_arb_n #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           hold_expired
);

  localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           grant_valid_q, grant_valid_d;
  logic           hold_expired_q, hold_expired_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;

  // Round-robin pick: first set request bit after last_q, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IDW'((32'(last_q) + off) % N);
      if (!win_found && request[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    grant_id_d     = grant_id_q;
    grant_valid_d  = grant_valid_q;
    hold_expired_d = 1'b0;
    last_d         = last_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d       = N'(1) << win_id;
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          last_d        = win_id;
          cnt_d         = CW'(1);
          state_d       = ST_GRANT;
        end else begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        // Release by the owner takes priority over the hold limit.
        if (!request[grant_id_q]) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else if ((MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD))) begin
          // last_q keeps the owner, so it drops to lowest priority.
          grant_d        = '0;
          grant_valid_d  = 1'b0;
          hold_expired_d = 1'b1;
          state_d        = ST_IDLE;
        end else if ((MAX_HOLD != 0) && (cnt_q != CW'(MAX_HOLD))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State registers; last_q resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      grant_id_q     <= '0;
      grant_valid_q  <= 1'b0;
      hold_expired_q <= 1'b0;
      last_q         <= IDW'(N - 1);
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_id_q     <= grant_id_d;
      grant_valid_q  <= grant_valid_d;
      hold_expired_q <= hold_expired_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign grant_id     = grant_id_q;
  assign grant_valid  = grant_valid_q;
  assign hold_expired = hold_expired_q;

endmodule

// File: doc/rr_arb_n.md
# rr_arb_n

Parametrised N-requester round-robin arbiter: the next generation of the team's two-requester arbiter. It issues a registered one-hot grant that is held until the owner drops its request. An optional hold-time limit forces release so one requester cannot starve the others. It sits between N bus masters and a shared resource, and has the same clock/reset and request/grant conventions as the existing two-requester arbiter.

## Interface
- N, 4, number of requesters (2..32)
- MAX_HOLD, 16, max consecutive grant cycles per tenure; 0 disables the limit
- IDW, $clog2(N) (minimum 1), width of grant_id (derived, not overridden)
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- request  input  N  per-requester request level; bit i = requester i
- grant  output  N  registered one-hot grant, or all-zero
- grant_id  output  IDW  index of current owner; valid only when grant_valid=1
- grant_valid  output  1  high when any grant bit is set (registered)
- hold_expired  output  1  one-cycle pulse, registered, when a tenure is cut by MAX_HOLD

## Operation
Reset (reset=0, asynchronous):
- grant=0, grant_id=0, grant_valid=0, hold_expired=0
- state=IDLE, hold counter=0, last_winner=N-1, so requester 0 has top priority first

State machine:
- IDLE
  - If request!=0, pick the first set bit searching last_winner+1, last_winner+2, … with wrap modulo N.
  - Register grant=one-hot(winner), grant_id=winner, grant_valid=1, last_winner=winner, counter=1.
  - Go to GRANT.
  - If request==0, stay in IDLE with all outputs 0.
- GRANT, owner o
  - If request[o]=0: grant=0, grant_valid=0, go to IDLE.
  - Else if MAX_HOLD!=0 and counter==MAX_HOLD: grant=0, grant_valid=0, hold_expired=1 for one cycle, go to IDLE. last_winner stays o, so o has lowest priority in the next arbitration.
  - Else hold the grant and increment the counter; it saturates at MAX_HOLD.
  - Changes on other request bits are ignored while in GRANT.

Rules:
- At most one grant bit is ever set.
- grant_id is held at its last value when grant_valid=0.
- A requester whose bit is 0 in IDLE is never granted.
- Counter width is $clog2(MAX_HOLD+1); when MAX_HOLD=0 the counter is unused and hold_expired is tied 0.

## Timing
- Grant latency: a request sampled high at edge k in IDLE gives grant asserted after edge k.
- Release: the owner drops its request before edge k, so grant drops after edge k. The state is IDLE for one cycle, and the next grant appears after edge k+1 at the earliest. There is always exactly one dead cycle between tenures.
- With MAX_HOLD=M, grant is high for at most M consecutive cycles. hold_expired is high in the cycle immediately after the last granted cycle, coincident with grant=0.
- Simultaneous requests in IDLE are resolved purely by the round-robin order from last_winner.
- If the owner drops its request in the same cycle the counter reaches M, the release path wins and hold_expired stays 0.
- Reset asserted mid-tenure clears all outputs immediately (asynchronously). After reset deassertion, the first grant is no earlier than the first rising edge.

## Test plan
- Reset check: N=4. Assert reset=0 for 3 cycles while request=4'b1111. Requires grant=0, grant_valid=0, hold_expired=0 throughout. Release reset: the first grant is 4'b0001, grant_id=0.
- Round-robin rotation: N=4, MAX_HOLD=0. Hold request=4'b1111 and drop each owner's bit for 1 cycle after 2 granted cycles. Required grant sequence: 0001, 0010, 0100, 1000, 0001, with one zero cycle between each tenure.
- Hold limit: N=4, MAX_HOLD=3. request=4'b0011 held constant. Requires grant=0001 for exactly 3 cycles, then 0000 with hold_expired=1, then 0010 for 3 cycles, then 0000 with hold_expired=1, then 0001.
- Non-preemption: N=4. Requester 2 is granted; raise request[0] mid-tenure. grant stays 0100 until request[2] falls. Next grant is 0001 after one dead cycle.
- Release versus limit collision: MAX_HOLD=2. Requester 1 drops its request in its 2nd granted cycle. Requires grant=0 in the next cycle and hold_expired=0.
- Async reset mid-tenure: grant=1000. Drive reset low between edges. grant and grant_valid go to 0 before the next edge. After release with request=4'b1001, the first grant is 0001 because last_winner is reset to 3.
